layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/npu_ctrl_pkg.sv | 23 ++
 rtl/layer_table.sv | 43 ++++
 rtl/layer_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_ctrl_pkg.sv
// Shared types for the NPU control path: layer type encoding and sequencer states.
package npu_ctrl_pkg;

  typedef enum logic [1:0] {
    VEC  = 2'b00,
    WINO = 2'b01,
    SE   = 2'b10,
    RSVD = 2'b11
  } layer_type_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } seq_state_e;

  function automatic logic is_runnable(input logic [1:0] t);
    return (t != RSVD);
  endfunction

endpackage

// File: rtl/layer_table.sv
// Layer type register file: one synchronous write port, one combinational read port,
// cleared to VEC by the asynchronous reset.
module layer_table
  import npu_ctrl_pkg::*;
#(
  parameter int MAX_LAYERS = 16,
  parameter int IDX_W      = $clog2(MAX_LAYERS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [1:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [1:0]       rdata
);

  logic [1:0] mem_q [MAX_LAYERS];
  logic [1:0] mem_d [MAX_LAYERS];

  // Next-state of every entry: only the addressed one takes the write data
  always_comb begin
    for (int i = 0; i < MAX_LAYERS; i++) begin
      mem_d[i] = (we && (waddr == IDX_W'(i))) ? wdata : mem_q[i];
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        mem_q[i] <= VEC;
      end
    end else begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/layer_sequencer.sv
// Walks the layer table, issuing one ctrl_start per layer and waiting for ctrl_done.
// Optional WAIT watchdog is compiled in with `define LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer
  import npu_ctrl_pkg::*;
#(
  parameter int MAX_LAYERS     = 16,
  parameter int IDX_W          = $clog2(MAX_LAYERS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [1:0]       cfg_type,
  input  logic [IDX_W:0]   num_layers,
  input  logic             net_start,
  input  logic             ctrl_done,
  output logic             ctrl_start,
  output logic [1:0]       layer_type,
  output logic [IDX_W-1:0] layer_idx,
  output logic             busy,
  output logic             net_done,
  output logic             err
);

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(MAX_LAYERS);

  if (MAX_LAYERS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("layer_sequencer: unsupported parameter values");
  end

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   nl_q, nl_d;
  logic [1:0]       type_q, type_d;
  logic             rsvd_q, rsvd_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wdog_q, wdog_d;
`endif

  logic             tbl_we;
  logic [IDX_W-1:0] rd_addr;
  logic [1:0]       rd_type;
  logic [1:0]       issue_type;
  logic             count_ok;
  logic             last_layer;
  logic             enter_issue;

  assign tbl_we     = cfg_we && (state_q == S_IDLE);
  assign count_ok   = (num_layers != '0) && (num_layers <= MAX_CNT);
  assign last_layer = (({1'b0, idx_q} + (IDX_W + 1)'(1)) == nl_q);
  // Look ahead to the entry the next ISSUE will use; forward a same-cycle write from IDLE
  assign rd_addr    = (state_q == S_IDLE) ? '0 : (idx_q + IDX_W'(1));
  assign issue_type = (tbl_we && (cfg_addr == '0)) ? cfg_type : rd_type;

  layer_table #(
    .MAX_LAYERS (MAX_LAYERS),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_type),
    .raddr (rd_addr),
    .rdata (rd_type)
  );

  // Next-state and registered-output logic of the sequencer
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    nl_d        = nl_q;
    type_d      = type_q;
    rsvd_d      = rsvd_q;
    err_d       = err_q;
    enter_issue = 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (net_start && count_ok) begin
          state_d     = S_ISSUE;
          idx_d       = '0;
          nl_d        = num_layers;
          err_d       = 1'b0;
          enter_issue = 1'b1;
        end else if (net_start) begin
          err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (rsvd_q) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
`ifdef LAYER_SEQ_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      S_WAIT: begin
        if (ctrl_done) begin
          state_d = S_NEXT;
`ifdef LAYER_SEQ_TIMEOUT_EN
        end else if (wdog_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d  = wdog_q + TO_W'(1);
`else
        end else begin
          state_d = S_WAIT;
`endif
        end
      end
      S_NEXT: begin
        if (last_layer) begin
          state_d = S_FINISH;
        end else begin
          idx_d       = idx_q + IDX_W'(1);
          state_d     = S_ISSUE;
          enter_issue = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A reserved entry still spends one ISSUE cycle, but without a start pulse
    if (enter_issue) begin
      rsvd_d = !is_runnable(issue_type);
      if (is_runnable(issue_type)) begin
        type_d = issue_type;
      end else begin
        type_d = type_q;
      end
    end else begin
      rsvd_d = rsvd_q;
    end

    start_d = enter_issue && is_runnable(issue_type);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FINISH);
  end

  // Sequencer state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      nl_q    <= '0;
      type_q  <= 2'b00;
      rsvd_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nl_q    <= nl_d;
      type_q  <= type_d;
      rsvd_q  <= rsvd_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LAYER_SEQ_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign ctrl_start = start_q;
  assign layer_type = type_q;
  assign layer_idx  = idx_q;
  assign busy       = busy_q;
  assign net_done   = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: vector table plus scoreboard of expected
// ctrl_start / net_done events, and hand-written multi-cycle sequences.
module tb_layer_sequencer;
  import npu_ctrl_pkg::*;

  localparam int MAXL = 16;
  localparam int IW   = 4;
`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [1:0]    cfg_type = 2'b00;
  logic [IW:0]   num_layers = '0;
  logic          net_start = 1'b0;
  logic          ctrl_done;
  logic          done_pulse = 1'b0;
  logic          done_tie = 1'b0;
  logic          ctrl_start, busy, net_done, err;
  logic [1:0]    layer_type;
  logic [IW-1:0] layer_idx;

  assign ctrl_done = done_pulse | done_tie;

  always #5 clk = ~clk;

  layer_sequencer #(
    .MAX_LAYERS     (MAXL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_type   (cfg_type),
    .num_layers (num_layers),
    .net_start  (net_start),
    .ctrl_done  (ctrl_done),
    .ctrl_start (ctrl_start),
    .layer_type (layer_type),
    .layer_idx  (layer_idx),
    .busy       (busy),
    .net_done   (net_done),
    .err        (err)
  );

  typedef struct {
    logic          is_done;
    logic [1:0]    typ;
    logic [IW-1:0] idx;
  } ev_t;

  typedef struct {
    logic [3:0][1:0] tbl;
    int              n;
    int              lat;
    int              exp_err;
    int              exp_starts;
    int              exp_done;
  } vec_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  n_starts = 0;
  int  n_dones = 0;
  int  cyc = 0;
  int  lat = 3;
  int  dcnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Controller model: pulse ctrl_done 'lat' cycles after each ctrl_start (lat 0 = never)
  initial forever begin
    @(negedge clk);
    done_pulse = 1'b0;
    if (ctrl_start && lat > 0) begin
      dcnt = lat;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) done_pulse = 1'b1;
    end
  end

  // Scoreboard: every start/done the DUT emits must match the head of the queue
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (ctrl_start) begin
        n_starts++;
        if (sb.size() == 0) begin
          check("unexpected_ctrl_start", 1, 0);
        end else begin
          e = sb.pop_front();
          check("event_kind_start", int'(e.is_done), 0);
          check("layer_type", int'(layer_type), int'(e.typ));
          check("layer_idx", int'(layer_idx), int'(e.idx));
        end
      end
      if (net_done) begin
        n_dones++;
        if (sb.size() == 0) begin
          check("unexpected_net_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("event_kind_done", int'(e.is_done), 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  function automatic vec_t make_vec(input logic [1:0] t0, input logic [1:0] t1,
                                    input logic [1:0] t2, input logic [1:0] t3,
                                    input int n, input int l, input int e,
                                    input int s, input int d);
    vec_t v;
    v.tbl[0] = t0; v.tbl[1] = t1; v.tbl[2] = t2; v.tbl[3] = t3;
    v.n = n; v.lat = l; v.exp_err = e; v.exp_starts = s; v.exp_done = d;
    return v;
  endfunction

  task automatic push_ev(input logic is_done, input logic [1:0] t, input int i);
    ev_t e;
    e.is_done = is_done;
    e.typ     = t;
    e.idx     = IW'(i);
    sb.push_back(e);
  endtask

  // Expected events: one start per layer until a reserved entry, then done if all ran
  task automatic push_expected(input logic [3:0][1:0] tbl, input int n);
    if (n < 1 || n > MAXL) return;
    for (int i = 0; i < n; i++) begin
      if (tbl[i] == 2'b11) return;
      push_ev(1'b0, tbl[i], i);
    end
    push_ev(1'b1, 2'b00, 0);
  endtask

  task automatic program_table(input logic [3:0][1:0] tbl);
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_addr = IW'(i); cfg_type = tbl[i];
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && busy; k++) @(negedge clk);
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_start(output int c);
    for (int k = 0; k < 100 && !ctrl_start; k++) @(negedge clk);
    check("start_seen", int'(ctrl_start), 1);
    c = cyc;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int s0, d0;
    program_table(v.tbl);
    lat = v.lat;
    push_expected(v.tbl, v.n);
    s0 = n_starts; d0 = n_dones;
    num_layers = (IW + 1)'(v.n);
    net_start = 1'b1;
    @(negedge clk);
    net_start = 1'b0;
    check($sformatf("v%0d_first_start", id), int'(ctrl_start), int'(v.exp_starts > 0));
    wait_idle();
    repeat (2) @(negedge clk);
    check($sformatf("v%0d_err", id), int'(err), v.exp_err);
    check($sformatf("v%0d_starts", id), n_starts - s0, v.exp_starts);
    check($sformatf("v%0d_dones", id), n_dones - d0, v.exp_done);
    check($sformatf("v%0d_sb_left", id), sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    vec_t vecs[8];
    logic [3:0][1:0] tbl;
    int c0, c1, s0, d0;

    vecs[0] = make_vec(VEC,  WINO, SE,   VEC, 3,  3, 0, 3, 1);
    vecs[1] = make_vec(VEC,  VEC,  VEC,  VEC, 0,  3, 1, 0, 0);
    vecs[2] = make_vec(WINO, RSVD, VEC,  VEC, 2,  2, 1, 1, 0);
    vecs[3] = make_vec(SE,   SE,   WINO, VEC, 4,  1, 0, 4, 1);
    vecs[4] = make_vec(WINO, VEC,  VEC,  VEC, 1,  5, 0, 1, 1);
    vecs[5] = make_vec(WINO, VEC,  VEC,  VEC, 17, 3, 1, 0, 0);
    vecs[6] = make_vec(RSVD, VEC,  VEC,  VEC, 1,  3, 1, 0, 0);
    vecs[7] = make_vec(VEC,  VEC,  VEC,  VEC, 1,  2, 0, 1, 1);

    repeat (3) @(negedge clk);
    check("reset_outputs", int'({ctrl_start, layer_type, layer_idx, busy, net_done, err}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset asserted while waiting on layer 1
    tbl[0] = SE; tbl[1] = WINO; tbl[2] = VEC; tbl[3] = VEC;
    program_table(tbl);
    lat = 20;
    push_expected(tbl, 2);
    num_layers = 5'd2; net_start = 1'b1;
    @(negedge clk);
    net_start = 1'b0;
    wait_start(c0);
    @(negedge clk);
    wait_start(c1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midwait_reset_outputs", int'({ctrl_start, layer_type, layer_idx, busy, net_done, err}), 0);
    sb.delete();
    dcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 2;
    push_ev(1'b0, VEC, 0);
    push_ev(1'b1, VEC, 0);
    num_layers = 5'd1; net_start = 1'b1;
    @(negedge clk);
    net_start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("post_reset_err", int'(err), 0);
    check("post_reset_sb_left", sb.size(), 0);

    // ctrl_done held high: two starts three cycles apart, then done
    tbl[0] = WINO; tbl[1] = SE;
    program_table(tbl);
    lat = 0; done_tie = 1'b1;
    push_expected(tbl, 2);
    s0 = n_starts; d0 = n_dones;
    num_layers = 5'd2; net_start = 1'b1;
    @(negedge clk);
    net_start = 1'b0;
    wait_start(c0);
    @(negedge clk);
    wait_start(c1);
    check("tied_gap", c1 - c0, 3);
    wait_idle();
    repeat (2) @(negedge clk);
    done_tie = 1'b0;
    check("tied_starts", n_starts - s0, 2);
    check("tied_dones", n_dones - d0, 1);
    check("tied_sb_left", sb.size(), 0);

    // Same-cycle write with net_start is used; writes and starts while busy are ignored
    tbl[0] = SE;
    program_table(tbl);
    lat = 5;
    push_ev(1'b0, WINO, 0);
    push_ev(1'b1, VEC, 0);
    cfg_we = 1'b1; cfg_addr = '0; cfg_type = WINO;
    num_layers = 5'd1; net_start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; net_start = 1'b0;
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = '0; cfg_type = RSVD;
    num_layers = 5'd2; net_start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; net_start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("fwd_err", int'(err), 0);
    check("fwd_sb_left", sb.size(), 0);
    push_ev(1'b0, WINO, 0);
    push_ev(1'b1, VEC, 0);
    num_layers = 5'd1; net_start = 1'b1;
    @(negedge clk);
    net_start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("busy_write_ignored_err", int'(err), 0);
    check("busy_write_sb_left", sb.size(), 0);

`ifdef LAYER_SEQ_TIMEOUT_EN
    // Watchdog: no ctrl_done ever returned
    lat = 0;
    push_ev(1'b0, WINO, 0);
    d0 = n_dones;
    num_layers = 5'd1; net_start = 1'b1;
    @(negedge clk);
    net_start = 1'b0;
    repeat (8) @(negedge clk);
    check("to_busy_before", int'(busy), 1);
    @(negedge clk);
    check("to_err", int'(err), 1);
    check("to_busy_after", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("to_no_done", n_dones - d0, 0);
    check("to_sb_left", sb.size(), 0);
    sb.delete();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
